snoopy_vertical_ctrl: RTL and testbench



---
 rtl/snoopy_vertical_ctrl_if.sv | 27 ++
 rtl/snoopy_vertical_ctrl.sv | 173 +++++++++++++++++
 tb/tb_snoopy_vertical_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/snoopy_vertical_ctrl_if.sv
// Jump/tick inputs and motion outputs of the Snoopy vertical-motion controller.
// master drives tick/jump (frame timing + button side); slave is the controller.
interface snoopy_vertical_ctrl_if #(
  parameter int Y_WIDTH   = 9,
  parameter int VEL_WIDTH = 8,
  parameter int JL_WIDTH  = 2
);
  logic                        tick;
  logic                        jump;
  logic [Y_WIDTH-1:0]          snoopy_y;
  logic signed [VEL_WIDTH-1:0] y_vel;
  logic [1:0]                  state;
  logic                        on_ground;
  logic [JL_WIDTH-1:0]         jumps_left;
  logic                        land_pulse;
  logic                        bump_pulse;

  modport master (
    output tick, jump,
    input  snoopy_y, y_vel, state, on_ground, jumps_left, land_pulse, bump_pulse
  );

  modport slave (
    input  tick, jump,
    output snoopy_y, y_vel, state, on_ground, jumps_left, land_pulse, bump_pulse
  );
endinterface

// File: rtl/snoopy_vertical_ctrl.sv
// Tick-paced vertical motion for Snoopy: multi-jump, early-release cut, terminal fall, clamps.
// Outputs update one clock after a tick edge; no backpressure, presses between ticks are latched.
module snoopy_vertical_ctrl #(
  parameter int Y_WIDTH   = 9,
  parameter int VEL_WIDTH = 8,
  parameter int GROUND_Y  = 50,
  parameter int CEILING_Y = 230,
  parameter int JUMP_VEL  = 20,
  parameter int GRAVITY   = 2,
  parameter int MAX_FALL  = 16,
  parameter int CUT_VEL   = 6,
  parameter int MAX_JUMPS = 2
) (
  input logic                  clock,
  input logic                  resetn,
  snoopy_vertical_ctrl_if.slave bus
);
  localparam int JW = $clog2(MAX_JUMPS + 1);
  localparam int EW = Y_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [Y_WIDTH-1:0]          GROUND_V  = Y_WIDTH'(GROUND_Y);
  localparam logic [Y_WIDTH-1:0]          CEILING_V = Y_WIDTH'(CEILING_Y);
  localparam logic signed [VEL_WIDTH-1:0] JUMP_V    = VEL_WIDTH'(JUMP_VEL);
  localparam logic signed [VEL_WIDTH-1:0] VEL_ZERO  = '0;
  localparam logic [JW-1:0]               JL_FULL   = JW'(MAX_JUMPS);
  localparam logic [JW-1:0]               JL_FIRST  = JW'(MAX_JUMPS - 1);
  localparam logic [JW-1:0]               JL_ONE    = JW'(1);

  // Extended-width constants so every add/compare happens without wrap.
  localparam logic signed [EW-1:0] GROUND_E = EW'(GROUND_Y);
  localparam logic signed [EW-1:0] CEIL_E   = EW'(CEILING_Y);
  localparam logic signed [EW-1:0] GRAV_E   = EW'(GRAVITY);
  localparam logic signed [EW-1:0] CUT_E    = EW'(CUT_VEL);
  localparam logic signed [EW-1:0] NFALL_E  = EW'(-MAX_FALL);
  localparam logic signed [EW-1:0] ZERO_E   = '0;

  state_t                      state_q, state_n;
  logic [Y_WIDTH-1:0]          y_q, y_n;
  logic signed [VEL_WIDTH-1:0] vel_q, vel_n;
  logic [JW-1:0]               jl_q, jl_n;
  logic                        pending_q, pending_n;
  logic                        jump_q;
  logic                        land_q, land_n;
  logic                        bump_q, bump_n;

  logic                        press;
  logic                        air_ok;
  logic signed [EW-1:0]        y_ext;
  logic signed [EW-1:0]        vel_ext;
  logic signed [EW-1:0]        v_rise;
  logic signed [EW-1:0]        yn_rise;
  logic signed [EW-1:0]        vg_rise;
  logic signed [EW-1:0]        v_fall_raw;
  logic signed [EW-1:0]        v_fall;
  logic signed [EW-1:0]        yn_fall;

  // A press on the tick clock itself is honoured rather than lost to the clear.
  assign press  = pending_q | (bus.jump & ~jump_q);
  assign air_ok = press && (jl_q != '0);

  assign y_ext   = $signed({2'b00, y_q});
  assign vel_ext = $signed({{(EW-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q});

  assign v_rise  = (!bus.jump && (vel_ext > CUT_E)) ? CUT_E : vel_ext;
  assign yn_rise = y_ext + v_rise;
  assign vg_rise = v_rise - GRAV_E;

  assign v_fall_raw = vel_ext - GRAV_E;
  assign v_fall     = (v_fall_raw < NFALL_E) ? NFALL_E : v_fall_raw;
  assign yn_fall    = y_ext + v_fall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      y_q       <= GROUND_V;
      vel_q     <= VEL_ZERO;
      jl_q      <= JL_FULL;
      pending_q <= 1'b0;
      jump_q    <= 1'b0;
      land_q    <= 1'b0;
      bump_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      y_q       <= y_n;
      vel_q     <= vel_n;
      jl_q      <= jl_n;
      pending_q <= pending_n;
      jump_q    <= bus.jump;
      land_q    <= land_n;
      bump_q    <= bump_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    y_n       = y_q;
    vel_n     = vel_q;
    jl_n      = jl_q;
    land_n    = 1'b0;
    bump_n    = 1'b0;
    pending_n = bus.tick ? 1'b0 : press;

    if (bus.tick) begin
      case (state_q)
        IDLE: begin
          if (press) begin
            vel_n   = JUMP_V;
            jl_n    = JL_FIRST;
            state_n = RISE;
          end
        end

        RISE: begin
          if (air_ok) begin
            vel_n = JUMP_V;
            jl_n  = jl_q - JL_ONE;
          end else if (yn_rise >= CEIL_E) begin
            y_n     = CEILING_V;
            vel_n   = VEL_ZERO;
            state_n = FALL;
            bump_n  = 1'b1;
          end else begin
            y_n   = yn_rise[Y_WIDTH-1:0];
            vel_n = vg_rise[VEL_WIDTH-1:0];
            if (vg_rise <= ZERO_E) begin
              state_n = FALL;
            end
          end
        end

        FALL: begin
          // An air jump wins over a landing on the same tick.
          if (air_ok) begin
            vel_n   = JUMP_V;
            jl_n    = jl_q - JL_ONE;
            state_n = RISE;
          end else if (yn_fall <= GROUND_E) begin
            y_n     = GROUND_V;
            vel_n   = VEL_ZERO;
            jl_n    = JL_FULL;
            state_n = IDLE;
            land_n  = 1'b1;
          end else begin
            y_n   = yn_fall[Y_WIDTH-1:0];
            vel_n = v_fall[VEL_WIDTH-1:0];
          end
        end

        default: begin
          state_n = IDLE;
          y_n     = GROUND_V;
          vel_n   = VEL_ZERO;
          jl_n    = JL_FULL;
        end
      endcase
    end
  end

  assign bus.snoopy_y   = y_q;
  assign bus.y_vel      = vel_q;
  assign bus.state      = state_q;
  assign bus.on_ground  = (state_q == IDLE);
  assign bus.jumps_left = jl_q;
  assign bus.land_pulse = land_q;
  assign bus.bump_pulse = bump_q;
endmodule

// File: tb/tb_snoopy_vertical_ctrl.sv
// Directed bench for snoopy_vertical_ctrl: expected motion queued per tick, checked by a monitor.
module tb_snoopy_vertical_ctrl;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RISE = 2'b01;
  localparam logic [1:0] S_FALL = 2'b10;

  localparam int R1Y [10] = '{70, 88, 104, 118, 130, 140, 148, 154, 158, 160};
  localparam int R1V [10] = '{18, 16, 14, 12, 10, 8, 6, 4, 2, 0};
  localparam int F1Y [10] = '{158, 154, 148, 140, 130, 118, 104, 88, 72, 56};
  localparam int F1V [10] = '{-2, -4, -6, -8, -10, -12, -14, -16, -16, -16};
  localparam int F3Y [14] = '{228, 224, 218, 210, 200, 188, 174, 158, 142, 126, 110, 94, 78, 62};
  localparam int F3V [14] = '{-2, -4, -6, -8, -10, -12, -14, -16, -16, -16, -16, -16, -16, -16};

  typedef struct packed {
    logic [8:0]        y;
    logic signed [7:0] vel;
    logic [1:0]        st;
    logic              og;
    logic [1:0]        jl;
    logic              land;
    logic              bump;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic tick_d = 1'b0;
  logic snap_req = 1'b0;
  logic done = 1'b0;
  logic final_done = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq [$];

  always #5 clock = ~clock;

  snoopy_vertical_ctrl_if #(.Y_WIDTH(9), .VEL_WIDTH(8), .JL_WIDTH(2)) bus ();

  snoopy_vertical_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always @(posedge clock) tick_d <= bus.tick;

  always @(negedge clock) begin
    exp_t e;
    exp_t g;
    if (tick_d || snap_req) begin
      if (sbq.size() == 0) begin
        checks <= checks + 1;
        errors <= errors + 1;
        $display("FAIL unexpected_output y=%0d with no expectation queued", bus.snoopy_y);
      end else begin
        e = sbq.pop_front();
        g.y = bus.snoopy_y;
        g.vel = bus.y_vel;
        g.st = bus.state;
        g.og = bus.on_ground;
        g.jl = bus.jumps_left;
        g.land = bus.land_pulse;
        g.bump = bus.bump_pulse;
        checks <= checks + 1;
        if (g !== e) begin
          errors <= errors + 1;
          $display("FAIL chk%0d got y=%0d vel=%0d st=%0d og=%0b jl=%0d land=%0b bump=%0b want y=%0d vel=%0d st=%0d og=%0b jl=%0d land=%0b bump=%0b",
                   checks, g.y, g.vel, g.st, g.og, g.jl, g.land, g.bump,
                   e.y, e.vel, e.st, e.og, e.jl, e.land, e.bump);
        end
      end
    end else if (done && !final_done) begin
      checks <= checks + 1;
      if (sbq.size() != 0) begin
        errors <= errors + 1;
        $display("FAIL leftover_expectations got %0d want 0", sbq.size());
      end
      final_done <= 1'b1;
    end
  end

  task automatic push(input int y, input int vel, input logic [1:0] st, input int jl,
                      input logic land, input logic bump);
    exp_t e;
    e.y    = 9'(y);
    e.vel  = 8'(vel);
    e.st   = st;
    e.og   = (st == S_IDLE);
    e.jl   = 2'(jl);
    e.land = land;
    e.bump = bump;
    sbq.push_back(e);
  endtask

  task automatic step(input int y, input int vel, input logic [1:0] st, input int jl,
                      input logic land, input logic bump);
    push(y, vel, st, jl, land, bump);
    @(posedge clock); #1 bus.tick = 1'b1;
    @(posedge clock); #1 bus.tick = 1'b0;
  endtask

  // Checks outputs at the coming falling edge, independent of any tick.
  task automatic snap(input int y, input int vel, input logic [1:0] st, input int jl,
                      input logic land, input logic bump);
    push(y, vel, st, jl, land, bump);
    snap_req = 1'b1;
    @(negedge clock); #1 snap_req = 1'b0;
  endtask

  task automatic set_jump(input logic v);
    @(posedge clock); #1 bus.jump = v;
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.jump = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    snap(50, 0, S_IDLE, 2, 0, 0);

    // Full held jump: launch, rise to apex, fall, land; held button must not relaunch.
    set_jump(1'b1);
    step(50, 20, S_RISE, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(R1Y[i], R1V[i], (i == 9) ? S_FALL : S_RISE, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(F1Y[i], F1V[i], S_FALL, 1, 0, 0);
    step(50, 0, S_IDLE, 2, 1, 0);
    @(posedge clock); #1;
    snap(50, 0, S_IDLE, 2, 0, 0);
    step(50, 0, S_IDLE, 2, 0, 0);
    set_jump(1'b0);

    // Early release cuts the rise; a press just above ground beats the landing.
    set_jump(1'b1);
    step(50, 20, S_RISE, 1, 0, 0);
    step(70, 18, S_RISE, 1, 0, 0);
    step(88, 16, S_RISE, 1, 0, 0);
    set_jump(1'b0);
    step(94, 4, S_RISE, 1, 0, 0);
    step(98, 2, S_RISE, 1, 0, 0);
    step(100, 0, S_FALL, 1, 0, 0);
    step(98, -2, S_FALL, 1, 0, 0);
    step(94, -4, S_FALL, 1, 0, 0);
    step(88, -6, S_FALL, 1, 0, 0);
    step(80, -8, S_FALL, 1, 0, 0);
    step(70, -10, S_FALL, 1, 0, 0);
    step(58, -12, S_FALL, 1, 0, 0);
    set_jump(1'b1);
    step(58, 20, S_RISE, 0, 0, 0);
    set_jump(1'b0);
    step(64, 4, S_RISE, 0, 0, 0);
    step(68, 2, S_RISE, 0, 0, 0);
    step(70, 0, S_FALL, 0, 0, 0);
    step(68, -2, S_FALL, 0, 0, 0);
    step(64, -4, S_FALL, 0, 0, 0);
    step(58, -6, S_FALL, 0, 0, 0);
    step(50, 0, S_IDLE, 2, 1, 0);

    // Double jump at 140, third press ignored, ceiling bump at 230, land restores jumps.
    set_jump(1'b1);
    step(50, 20, S_RISE, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(R1Y[i], R1V[i], S_RISE, 1, 0, 0);
    set_jump(1'b0);
    set_jump(1'b1);
    step(140, 20, S_RISE, 0, 0, 0);
    set_jump(1'b0);
    set_jump(1'b1);
    step(160, 18, S_RISE, 0, 0, 0);
    step(178, 16, S_RISE, 0, 0, 0);
    step(194, 14, S_RISE, 0, 0, 0);
    step(208, 12, S_RISE, 0, 0, 0);
    step(220, 10, S_RISE, 0, 0, 0);
    step(230, 0, S_FALL, 0, 0, 1);
    for (int i = 0; i < 14; i++) step(F3Y[i], F3V[i], S_FALL, 0, 0, 0);
    step(50, 0, S_IDLE, 2, 1, 0);
    step(50, 0, S_IDLE, 2, 0, 0);
    set_jump(1'b0);

    // Press and release entirely between ticks still launches.
    set_jump(1'b1);
    set_jump(1'b0);
    step(50, 20, S_RISE, 1, 0, 0);
    step(56, 4, S_RISE, 1, 0, 0);
    step(60, 2, S_RISE, 1, 0, 0);
    step(62, 0, S_FALL, 1, 0, 0);
    step(60, -2, S_FALL, 1, 0, 0);
    step(56, -4, S_FALL, 1, 0, 0);
    step(50, 0, S_IDLE, 2, 1, 0);

    // Async reset mid-air returns to rest at once with no landing pulse.
    set_jump(1'b1);
    step(50, 20, S_RISE, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(R1Y[i], R1V[i], S_RISE, 1, 0, 0);
    @(posedge clock); #1 resetn = 1'b0;
    snap(50, 0, S_IDLE, 2, 0, 0);
    bus.jump = 1'b0;
    @(posedge clock); #1 resetn = 1'b1;
    step(50, 0, S_IDLE, 2, 0, 0);

    repeat (3) @(posedge clock);
    #1 done = 1'b1;
    repeat (4) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
